inv_addkey_mix: RTL
===================

INV_ADDKEY_MIX -- requirements
Module: inv_addkey_mix

Interface
REQ-001 Parameter: CLR_ON_DONE, 0, when 1 s_o is cleared to 0 in the cycle after the output handshake; when 0 s_o holds its last value.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 Port: s_in  input  128  state from the inverse-S-box stage; column c = s_in[127-32c -: 32], row r of column c = s_in[127-32c-8r -: 8].
REQ-005 Port: rk_in  input  128  round key, same byte layout as s_in.
REQ-006 Port: last_round  input  1  1 = final decryption round, InvMixColumns skipped.
REQ-007 Port: in_valid  input  1  s_in, rk_in and last_round valid.
REQ-008 Port: in_ready  output  1  block can accept a new state.
REQ-009 Port: s_o  output  128  result, same byte layout.
REQ-010 Port: out_valid  output  1  s_o holds a completed result.
REQ-011 Port: out_ready  input  1  downstream accepts s_o.

Function
REQ-012 FSM states: IDLE, MIX, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 IDLE: on in_valid && in_ready, the block registers work = s_in ^ rk_in and latches last_round. If last_round = 1 it goes to DONE with s_o = work; otherwise it goes to MIX with the column counter at 0.
REQ-014 MIX: processes one column per cycle, in order column 0,1,2,3, using a 2-bit counter. After column 3 the counter wraps to 0, the block loads s_o with the full result and goes to DONE.
REQ-015 InvMixColumns per column: out_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), indices mod 4, multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
REQ-016 Latency from the accept edge (cycle 0): out_valid is 1 at cycle 5 for mix rounds and at cycle 1 when last_round = 1.
REQ-017 DONE: s_o and out_valid are held stable until out_ready = 1. On out_valid && out_ready the block returns to IDLE, and in_ready = 1 in the following cycle.
REQ-018 in_valid is ignored outside IDLE; no new input is accepted in the cycle of an output handshake.
REQ-019 Changes on s_in, rk_in or last_round after the accept edge do not affect the result in progress.
REQ-020 Throughput: 1 block per 6 cycles (mix) or 2 cycles (last round) with out_ready held at 1.

Reset
REQ-021 With rst = 0 at a clk edge, the block forces the following: state IDLE, counter 0, work 0, s_o 0, out_valid 0. in_ready reads 1 from the next cycle.
REQ-022 A reset asserted in MIX or DONE aborts the operation, and no out_valid is produced for the aborted block.

Configuration
REQ-023 Macro ADDKEY_MIX_PARALLEL_EN, when defined: MIX computes all four columns in a single cycle, so mix-round latency is 2 cycles and throughput is 1 block per 3 cycles.
REQ-024 Macro ADDKEY_MIX_PARALLEL_EN, when undefined: the column-serial datapath of REQ-014 applies, with a single column multiplier instance.
REQ-025 Both builds produce identical s_o values and use an identical handshake protocol.

Verification
REQ-026 Mix round: rk_in = 0, last_round = 0, s_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6. Required: s_o = db135345_f20a225c_01010101_c6c6c6c6, with out_valid at cycle 5.
REQ-027 Key applied before mixing: s_in = 0, rk_in = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, last_round = 0. Required: the same s_o as REQ-026.
REQ-028 Last round: s_in = all FF, rk_in = all 0F, last_round = 1. Required: s_o = all F0, with out_valid at cycle 1.
REQ-029 Backpressure: out_ready = 0 for 3 cycles after out_valid. Required: s_o stable and in_ready = 0 throughout; handshake on the 4th cycle; in_ready = 1 the next cycle.
REQ-030 Reset mid-operation: rst = 0 at cycle 2 of REQ-026. Required: s_o = 0, out_valid = 0 and in_ready = 1 the following cycle; no result is produced.
REQ-031 ADDKEY_MIX_PARALLEL_EN defined, REQ-026 stimulus: same s_o, with out_valid at cycle 2.

Source files
------------

// File: rtl/inv_addkey_mix.sv
// AES decryption round tail: AddRoundKey followed by InvMixColumns (skipped on the last round).
// Define ADDKEY_MIX_PARALLEL_EN to mix all four columns in one cycle instead of one per cycle.
module inv_addkey_mix #(
    parameter int unsigned CLR_ON_DONE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] s_in,
    input  logic [127:0] rk_in,
    input  logic         last_round,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] s_o,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    // Index 0 is the most significant word, i.e. column 0.
    logic [0:3][31:0] work_q, work_d;
    logic [0:3][31:0] s_q, s_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [0:3][7:0] a;
        logic [0:3][7:0] o;
        a = c;
        o[0] = mul14(a[0]) ^ mul11(a[1]) ^ mul13(a[2]) ^ mul9(a[3]);
        o[1] = mul14(a[1]) ^ mul11(a[2]) ^ mul13(a[3]) ^ mul9(a[0]);
        o[2] = mul14(a[2]) ^ mul11(a[3]) ^ mul13(a[0]) ^ mul9(a[1]);
        o[3] = mul14(a[3]) ^ mul11(a[0]) ^ mul13(a[1]) ^ mul9(a[2]);
        return o;
    endfunction

`ifndef ADDKEY_MIX_PARALLEL_EN
    logic [31:0] col_mix;

    // Single shared column multiplier, steered by the column counter.
    always_comb begin
        col_mix = inv_mix_col(work_q[cnt_q]);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = s_in ^ rk_in;
                    if (last_round) begin
                        s_d     = s_in ^ rk_in;
                        state_d = DONE;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = MIX;
                    end
                end
            end
            MIX: begin
`ifdef ADDKEY_MIX_PARALLEL_EN
                s_d = {inv_mix_col(work_q[0]), inv_mix_col(work_q[1]),
                       inv_mix_col(work_q[2]), inv_mix_col(work_q[3])};
                state_d = DONE;
`else
                work_d[cnt_q] = col_mix;
                cnt_d         = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    s_d     = work_d;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    if (CLR_ON_DONE != 0) begin
                        s_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            work_q  <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            s_q     <= s_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s_o       = s_q;

endmodule
